pulse_period_meter: RTL
=======================

// Module: pulse_period_meter
//
// PURPOSE
//  Receive-side counterpart of the N-clock pulse generator: samples a pulse train
//  on `in`, measures clocks between consecutive rising edges and reports each
//  period on a valid/ready result port.
//  Each period is compared against EXPECTED_N, giving a per-sample match flag.
//  Sits next to the generator in bench/self-check datapaths; same clock domain.
//
// PARAMETERS
//  W           8   counter/result width; max reportable period 2**W-1
//  EXPECTED_N  4   nominal period in clocks; must be >= 2 and <= 2**W-1
//  TIMEOUT     64  clocks without an edge before timeout (only with the CONFIGURATION macro)
//
// PORTS
//  clock    in   1  single system clock, all logic on posedge
//  reset    in   1  synchronous, active-high reset
//  in       in   1  pulse train, synchronous to clock
//  period   out  W  measured period of the last accepted sample
//  match    out  1  period == EXPECTED_N and not saturated; qualified by valid
//  sat      out  1  counter saturated during this sample; period = 2**W-1
//  valid    out  1  result available
//  ready    in   1  consumer accepts result when valid && ready
//  overrun  out  1  sticky: a completed sample was dropped; cleared only by reset
//  timeout  out  1  sticky no-edge indication (macro-dependent, else tied 0)
//
// BEHAVIOUR
//  - Reset (sync, priority over all): state=WAIT_FIRST, in_q=0, cnt=0, period=0,
//    match=0, sat=0, valid=0, overrun=0, timeout=0. Reset mid-sample discards it.
//  - Edge: rise = in & ~in_q; in_q <= in every clock. Level-high `in` = one edge.
//  - FSM WAIT_FIRST: on rise -> MEASURE, cnt<=1. No result for the first edge.
//  - FSM MEASURE: no rise -> cnt<=cnt+1, saturating at 2**W-1 (sat_q<=1 on hit).
//    rise -> sample done: value=cnt; cnt<=1; sat_q<=0; stay in MEASURE.
//  - Period = clocks from edge to edge: pulses every N clocks report N.
//  - Latency: valid rises the clock after the cycle where the closing rise is seen.
//  - Result capture when sample done and (!valid || ready): period<=value,
//    sat<=sat_q, match<=(value==EXPECTED_N)&&!sat_q, valid<=1.
//  - Sample done while valid && !ready: new sample dropped, old result held,
//    overrun<=1. Done in the same cycle as handshake: new result captured, valid stays 1.
//  - valid && ready with no new sample: valid<=0 next clock; period/match/sat hold.
//  - period/match/sat stable while valid=1 and ready=0 (AXI-style hold rule).
//
// CONFIGURATION
//  PULSE_METER_TIMEOUT_EN defined: in MEASURE, cnt reaching TIMEOUT without an
//    edge sets timeout<=1 (sticky) and returns FSM to WAIT_FIRST (no result issued);
//    next edge restarts measurement. Requires TIMEOUT <= 2**W-1.
//  Undefined: timeout tied 0, counter simply saturates, no state change.
//
// STRUCTURE
//  Package pulse_meter_pkg: state encoding (WAIT_FIRST=1'b0, MEASURE=1'b1),
//    result-capture/overrun helper constants, default W/EXPECTED_N/TIMEOUT.
//  Sub-module rise_detect (clock, reset, in -> rise): the in_q register + AND.
//  Top holds FSM, saturating counter, result register and handshake.
//
// TESTING
//  1 Generator N=4, ready=1 -> first edge no result; then period=4, match=1 each pulse.
//  2 N=7 vs EXPECTED_N=4 -> period=7, match=0, sat=0 every sample.
//  3 ready=0 for 3 samples (N=4) -> first result held, overrun=1; ready=1 -> valid drops.
//  4 W=4, edges 20 clocks apart -> period=15, sat=1, match=0.
//  5 Reset pulse mid-sample -> all outputs 0 next clock, next edge treated as first.
//  6 TIMEOUT_EN, TIMEOUT=10, in held 0 after one pulse -> timeout=1 at cnt=10, WAIT_FIRST.

Source files
------------

// File: rtl/pulse_meter_pkg.sv
// Shared types and defaults for the pulse period meter.
// Optional feature macro used by the top: PULSE_METER_TIMEOUT_EN.
package pulse_meter_pkg;

  typedef enum logic {
    WAIT_FIRST = 1'b0,
    MEASURE    = 1'b1
  } state_t;

  localparam int DEF_W          = 8;
  localparam int DEF_EXPECTED_N = 4;
  localparam int DEF_TIMEOUT    = 64;

  // A finished sample may enter the result register only if the slot is free
  // or is being handed off in the same cycle.
  function automatic logic can_capture(input logic valid, input logic ready);
    return !valid || ready;
  endfunction

endpackage

// File: rtl/pulse_period_meter_rise_detect.sv
// Rising-edge detector: registers the pulse train and flags a 0->1 transition.
module rise_detect (
  input  logic clock,
  input  logic reset,
  input  logic in,
  output logic rise
);

  logic in_q;

  always_ff @(posedge clock) begin
    if (reset) in_q <= 1'b0;
    else       in_q <= in;
  end

  assign rise = in & ~in_q;

endmodule

// File: rtl/pulse_period_meter.sv
// Measures clocks between rising edges of `in` and offers each period on a
// valid/ready port. Optional no-edge timeout: define PULSE_METER_TIMEOUT_EN.
module pulse_period_meter
  import pulse_meter_pkg::*;
#(
  parameter int W          = DEF_W,
  parameter int EXPECTED_N = DEF_EXPECTED_N,
  parameter int TIMEOUT    = DEF_TIMEOUT
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         in,
  output logic [W-1:0] period,
  output logic         match,
  output logic         sat,
  output logic         valid,
  input  logic         ready,
  output logic         overrun,
  output logic         timeout,
  output state_t       fsm_state
);

  // Handshake: a result transfers on a clock where valid && ready; while
  // valid is high and ready low, period/match/sat are held unchanged.

  localparam logic [W-1:0] CNT_MAX = {W{1'b1}};
  localparam logic [W-1:0] EXP_VAL = W'(EXPECTED_N);

  state_t         state, state_d;
  logic [W-1:0]   cnt, cnt_d;
  logic           sat_q, sat_d;
  logic           rise;
  logic           done;

  rise_detect u_rise (
    .clock (clock),
    .reset (reset),
    .in    (in),
    .rise  (rise)
  );

`ifdef PULSE_METER_TIMEOUT_EN
  localparam logic [W-1:0] TO_VAL = W'(TIMEOUT);
  logic timeout_q, timeout_d;

  always_ff @(posedge clock) begin
    if (reset) timeout_q <= 1'b0;
    else       timeout_q <= timeout_d;
  end

  assign timeout = timeout_q;
`else
  logic [W-1:0] unused_timeout;
  assign unused_timeout = W'(TIMEOUT);
  assign timeout        = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= WAIT_FIRST;
      cnt   <= '0;
      sat_q <= 1'b0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      sat_q <= sat_d;
    end
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    sat_d   = sat_q;
    done    = 1'b0;
`ifdef PULSE_METER_TIMEOUT_EN
    timeout_d = timeout_q;
`endif
    case (state)
      WAIT_FIRST: begin
        if (rise) begin
          state_d = MEASURE;
          cnt_d   = W'(1);
          sat_d   = 1'b0;
        end
      end
      MEASURE: begin
        if (rise) begin
          done  = 1'b1;
          cnt_d = W'(1);
          sat_d = 1'b0;
        end
`ifdef PULSE_METER_TIMEOUT_EN
        else if (cnt == TO_VAL) begin
          timeout_d = 1'b1;
          state_d   = WAIT_FIRST;
          cnt_d     = '0;
          sat_d     = 1'b0;
        end
`endif
        else if (cnt != CNT_MAX) begin
          // Reaching the ceiling marks the sample as clipped.
          cnt_d = cnt + 1'b1;
          if (cnt == CNT_MAX - 1'b1) sat_d = 1'b1;
        end
      end
      default: state_d = WAIT_FIRST;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      period  <= '0;
      match   <= 1'b0;
      sat     <= 1'b0;
      valid   <= 1'b0;
      overrun <= 1'b0;
    end else if (done) begin
      if (can_capture(valid, ready)) begin
        period <= cnt;
        sat    <= sat_q;
        match  <= (cnt == EXP_VAL) && !sat_q;
        valid  <= 1'b1;
      end else begin
        overrun <= 1'b1;
      end
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

  assign fsm_state = state;

endmodule
